// File: rtl/rds_group_tx.sv
// RDS group-0B transmitter: builds A/B/C'/D blocks with serial CRC check words.
// It emits 104-bit groups at an NCO-derived bit rate with differential encoding.
module rds_group_tx #(
    parameter logic [31:0] NCO_INC = 32'd204011,
    parameter logic        TP      = 1'b0,
    parameter logic [4:0]  PTY     = 5'd0,
    parameter logic        MS      = 1'b1
) (
    input  logic        clk_25m,
    input  logic        reset,
    input  logic        tx_en,
    input  logic [15:0] pi_code,
    input  logic        ta,
    input  logic        ps_we,
    input  logic [2:0]  ps_addr,
    input  logic [7:0]  ps_data,
    output logic        rds_bit,
    output logic        rds_raw,
    output logic        bit_strobe,
    output logic [1:0]  block_idx,
    output logic        group_start
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [9:0] GEN_POLY = 10'h1B9;

    logic [1:0]  state;
    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        tick;
    logic [1:0]  seg;
    logic [1:0]  cur_idx;
    logic [4:0]  bit_cnt;
    logic [3:0]  load_cnt;
    logic [15:0] info;
    logic [9:0]  crc;
    logic [7:0]  ps_mem [0:7];

    logic [1:0]  next_idx;
    logic [1:0]  next_seg;
    logic [15:0] next_info;
    logic [9:0]  offset;
    logic [25:0] block_word;
    logic        present;
    logic        end_block;
    logic        enter_load;
    logic        next_bit;
    logic        crc_fb;

    assign acc_sum = {1'b0, acc} + {1'b0, NCO_INC};
    assign tick    = (state != ST_IDLE) && acc_sum[32];

    // The last LOAD cycle may already catch a tick; bit 0 never needs the CRC,
    // so presenting it there keeps the bit spacing even when ticks are close.
    assign present    = tick && ((state == ST_SEND) ||
                                 ((state == ST_LOAD) && (load_cnt == 4'd15)));
    assign end_block  = present && (state == ST_SEND) && (bit_cnt == 5'd25);
    assign enter_load = ((state == ST_IDLE) && tx_en) ||
                        (end_block && ((cur_idx != 2'd3) || tx_en));

    assign crc_fb     = info[4'd15 - load_cnt] ^ crc[9];
    assign block_word = {info, crc ^ offset};
    assign next_bit   = block_word[5'd25 - bit_cnt];

    always_comb begin
        next_idx  = (state == ST_SEND) ? cur_idx + 2'd1 : 2'd0;
        next_seg  = ((state == ST_SEND) && (cur_idx == 2'd3)) ? seg + 2'd1 : seg;
        next_info = pi_code;
        case (next_idx)
            2'd1:    next_info = {4'b0000, 1'b1, TP, PTY, ta, MS, 1'b0, next_seg};
            2'd3:    next_info = {ps_mem[{next_seg, 1'b0}], ps_mem[{next_seg, 1'b1}]};
            default: next_info = pi_code;
        endcase
    end

    always_comb begin
        offset = 10'h0FC;
        case (cur_idx)
            2'd1:    offset = 10'h198;
            2'd2:    offset = 10'h350;
            2'd3:    offset = 10'h1B4;
            default: offset = 10'h0FC;
        endcase
    end

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            state       <= ST_IDLE;
            acc         <= 32'd0;
            seg         <= 2'd0;
            cur_idx     <= 2'd0;
            bit_cnt     <= 5'd0;
            load_cnt    <= 4'd0;
            info        <= 16'd0;
            crc         <= 10'd0;
            block_idx   <= 2'd0;
            rds_bit     <= 1'b0;
            rds_raw     <= 1'b0;
            bit_strobe  <= 1'b0;
            group_start <= 1'b0;
            for (int i = 0; i < 8; i++) ps_mem[i] <= 8'h20;
        end else begin
            bit_strobe  <= present;
            group_start <= present && (cur_idx == 2'd0) && (bit_cnt == 5'd0);
            if (present) begin
                rds_raw   <= next_bit;
                rds_bit   <= rds_bit ^ next_bit;
                block_idx <= cur_idx;
            end
            if (state != ST_IDLE) acc <= acc_sum[31:0];
            if (ps_we) ps_mem[ps_addr] <= ps_data;

            case (state)
                ST_LOAD: begin
                    crc      <= {crc[8:0], 1'b0} ^ (crc_fb ? GEN_POLY : 10'd0);
                    load_cnt <= load_cnt + 4'd1;
                    if (load_cnt == 4'd15) begin
                        state   <= ST_SEND;
                        bit_cnt <= present ? 5'd1 : 5'd0;
                    end
                end
                ST_SEND: begin
                    if (present) begin
                        if (bit_cnt == 5'd25) begin
                            state   <= ST_IDLE;
                            cur_idx <= 2'd0;
                            seg     <= next_seg;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: ;
            endcase

            // Snapshot the next block's info; overrides the IDLE choice above.
            if (enter_load) begin
                state    <= ST_LOAD;
                info     <= next_info;
                cur_idx  <= next_idx;
                seg      <= next_seg;
                crc      <= 10'd0;
                load_cnt <= 4'd0;
                bit_cnt  <= 5'd0;
            end
        end
    end

endmodule
